// File: rtl/cpc_kbd_pkg.sv
// Shared definitions for the CPC keyboard matrix scanner: sizes, event
// field positions, key-code packing and the scanner FSM state type.
package cpc_kbd_pkg;

  localparam int unsigned CPC_ROWS = 10;
  localparam int unsigned ROW_W    = 4;
  localparam int unsigned COL_W    = 3;
  localparam int unsigned COL_N    = 8;
  localparam int unsigned CODE_W   = 8;
  localparam int unsigned EV_W     = 11;

  // Event bit positions; [8] is always 0 and [7:0] carries the key code.
  localparam int unsigned EV_TGL   = 10;
  localparam int unsigned EV_PRESS = 9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SAMPLE = 3'd2,
    EMIT   = 3'd3,
    NEXT   = 3'd4
  } kms_state_t;

  // Key code as seen by ps2_key-format consumers: {0, row, col}.
  function automatic logic [CODE_W-1:0] cpc_key_code(input logic [ROW_W-1:0] row,
                                                     input logic [COL_W-1:0] col);
    return {1'b0, row, col};
  endfunction

endpackage

// File: rtl/lsb_pick8.sv
// Lowest-set-bit priority encoder over an 8-bit vector (purely combinational).
module lsb_pick8 (
  input  logic [7:0] vec_i,
  output logic       valid_c_o,
  output logic [2:0] idx_c_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid_c_o = 1'b0;
    idx_c_o   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec_i[i]) begin
        valid_c_o = 1'b1;
        idx_c_o   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/kbd_matrix_scan.sv
// CPC keyboard matrix scanner: walks the rows, keeps a pressed-key image and
// reports each key change as a toggle-strobed ps2_key-style event.
module kbd_matrix_scan
  import cpc_kbd_pkg::*;
#(
  parameter int unsigned ROWS     = CPC_ROWS,
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned SCAN_GAP = 1024,
  parameter int unsigned EV_GAP   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan_en,
  output logic [ROW_W-1:0] Y,
  input  logic [COL_N-1:0] X,
  output logic [EV_W-1:0]  ev,
  output logic             busy,
  output logic             scan_done
);

  localparam int unsigned CNT_MAX =
    (SCAN_GAP > SETTLE) ? ((SCAN_GAP > EV_GAP) ? SCAN_GAP : EV_GAP)
                        : ((SETTLE > EV_GAP) ? SETTLE : EV_GAP);
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(SCAN_GAP - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] EVG_LAST = CNT_W'(EV_GAP - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  kms_state_t                  state_q, state_d;
  logic [ROW_W-1:0]            row_q, row_d;
  logic [ROW_W-1:0]            y_q, y_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [ROWS-1:0][COL_N-1:0]  img_q, img_d;
  logic [COL_N-1:0]            diff_q, diff_d;
  logic [EV_W-1:0]             ev_q, ev_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic [COL_N-1:0] img_row;
  logic [COL_N-1:0] diff_now;
  logic [COL_N-1:0] diff_cur;
  logic [COL_N-1:0] pick_bit;
  logic             pick_vld;
  logic [COL_W-1:0] pick_idx;
  logic [EV_W-1:0]  ev_emit;

  // In SAMPLE the change set comes straight from X; in EMIT from the held copy.
  assign img_row  = img_q[row_q];
  assign diff_now = (~X) ^ img_row;
  assign diff_cur = (state_q == SAMPLE) ? diff_now : diff_q;
  assign pick_bit = COL_N'(1) << pick_idx;

  lsb_pick8 u_pick (
    .vec_i     (diff_cur),
    .valid_c_o (pick_vld),
    .idx_c_o   (pick_idx)
  );

  // Event for the picked column; a differing bit means its new state is ~img.
  always_comb begin
    ev_emit             = ev_q;
    ev_emit[EV_TGL]     = ~ev_q[EV_TGL];
    ev_emit[EV_PRESS]   = ~img_row[pick_idx];
    ev_emit[EV_PRESS-1] = 1'b0;
    ev_emit[7:0]        = cpc_key_code(row_q, pick_idx);
  end

  // Next-state and output logic for the scan FSM.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    img_d   = img_q;
    diff_d  = diff_q;
    ev_d    = ev_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cnt_q == GAP_LAST) begin
          if (scan_en) begin
            row_d   = '0;
            y_d     = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = DRIVE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DRIVE: begin
        if (cnt_q == SET_LAST) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      SAMPLE: begin
        if (pick_vld) begin
          ev_d           = ev_emit;
          img_d[row_q]   = img_row ^ pick_bit;
          diff_d         = diff_now & ~pick_bit;
          cnt_d          = '0;
          state_d        = EMIT;
        end else begin
          diff_d  = '0;
          state_d = NEXT;
        end
      end

      EMIT: begin
        if (cnt_q == EVG_LAST) begin
          cnt_d = '0;
          if (pick_vld) begin
            ev_d         = ev_emit;
            img_d[row_q] = img_row ^ pick_bit;
            diff_d       = diff_q & ~pick_bit;
          end else begin
            state_d = NEXT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      NEXT: begin
        cnt_d = '0;
        if (row_q == ROW_LAST) begin
          done_d  = 1'b1;
          row_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (!scan_en) begin
          row_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          row_d   = row_q + 1'b1;
          y_d     = row_q + 1'b1;
          state_d = DRIVE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset also drops any event in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      img_q   <= '0;
      diff_q  <= '0;
      ev_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      img_q   <= img_d;
      diff_q  <= diff_d;
      ev_q    <= ev_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Y         = y_q;
  assign ev        = ev_q;
  assign busy      = busy_q;
  assign scan_done = done_q;

endmodule

// File: tb/tb_kbd_matrix_scan.sv
// Self-checking bench for kbd_matrix_scan: directed vector table, reset and
// scan_en corner sequences, then random matrix changes against a key-image model.
module tb_kbd_matrix_scan;

  localparam int ROWS_N      = 10;
  localparam int EV_GAP_N    = 4;
  localparam int SCAN_PERIOD = 1064;
  localparam int FIRST_LAT   = 3;
  localparam int BUDGET      = 4000;

  logic        clk;
  logic        reset;
  logic        scan_en;
  logic [3:0]  Y;
  logic [7:0]  X;
  logic [10:0] ev;
  logic        busy;
  logic        scan_done;

  logic [7:0] x_mat [ROWS_N];
  logic [7:0] img_m [ROWS_N];

  int cyc       = 0;
  int checks    = 0;
  int failures  = 0;
  int done_cnt  = 0;
  int prev_done = -1;
  int last_int  = 0;
  bit int_valid = 1'b0;
  int eb, yb, d0;

  logic       prev_tgl  = 1'b0;
  logic       busy_prev = 1'b0;
  logic [3:0] y_prev    = 4'd0;

  logic [9:0] ev_log [$];
  int         ev_cyc [$];
  logic [3:0] y_log  [$];
  int         y_cyc  [$];
  logic [9:0] exp_q  [$];

  typedef struct {
    int         row;
    logic [7:0] x;
    int         n;
    logic [9:0] e0;
    logic [9:0] e1;
    logic [9:0] e2;
  } vec_t;

  vec_t tbl [9];

  kbd_matrix_scan dut (
    .clk       (clk),
    .reset     (reset),
    .scan_en   (scan_en),
    .Y         (Y),
    .X         (X),
    .ev        (ev),
    .busy      (busy),
    .scan_done (scan_done)
  );

  assign X = (Y < 4'd10) ? x_mat[Y] : 8'hFF;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: logs event toggles, scan_done spacing and the rows driven.
  always @(negedge clk) begin
    if (reset) begin
      prev_tgl  = 1'b0;
      int_valid = 1'b0;
      prev_done = -1;
    end else begin
      if (ev[10] !== prev_tgl) begin
        ev_log.push_back(ev[9:0]);
        ev_cyc.push_back(cyc);
        prev_tgl = ev[10];
      end
      if (scan_done) begin
        done_cnt++;
        if (prev_done >= 0) begin
          last_int  = cyc - prev_done;
          int_valid = 1'b1;
        end
        prev_done = cyc;
      end
      if (busy && (!busy_prev || Y != y_prev)) begin
        y_log.push_back(Y);
        y_cyc.push_back(cyc);
      end
    end
    busy_prev = busy;
    y_prev    = Y;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic begin_scan();
    eb = ev_log.size();
    yb = y_log.size();
    d0 = done_cnt;
  endtask

  // Reference: one full scan reports every key whose state differs from the
  // image, row-major, lowest column first, then the image follows the matrix.
  task automatic model_scan();
    logic p;
    exp_q.delete();
    for (int r = 0; r < ROWS_N; r++) begin
      for (int c = 0; c < 8; c++) begin
        p = ~x_mat[r][c];
        if (p != img_m[r][c]) begin
          exp_q.push_back({p, 1'b0, 1'b0, 4'(r), 3'(c)});
          img_m[r][c] = p;
        end
      end
    end
  endtask

  task automatic run_scan(input string name, input bit chk_period);
    int n;
    int ne;
    int errs;
    n = 0;
    while (done_cnt == d0 && n < BUDGET) begin
      wait_neg();
      n++;
    end
    check({name, "_done"}, done_cnt - d0, 1);
    ne = ev_log.size() - eb;
    check({name, "_nev"}, ne, exp_q.size());
    for (int i = 0; i < ne && i < exp_q.size(); i++)
      check({name, "_ev"}, int'(ev_log[eb+i]), int'(exp_q[i]));
    for (int i = 1; i < ne; i++)
      if (ev_log[eb+i][6:3] == ev_log[eb+i-1][6:3])
        check({name, "_gap"}, ev_cyc[eb+i] - ev_cyc[eb+i-1], EV_GAP_N);
    check({name, "_yn"}, y_log.size() - yb, ROWS_N);
    errs = 0;
    for (int i = 0; i < ROWS_N && yb + i < y_log.size(); i++)
      if (int'(y_log[yb+i]) != i) errs++;
    check({name, "_ywalk"}, errs, 0);
    if (chk_period && int_valid)
      check({name, "_period"}, last_int, SCAN_PERIOD + EV_GAP_N * exp_q.size());
  endtask

  initial begin
    int         n;
    int         ym;
    int         np;
    logic [7:0] v;

    reset   = 1'b1;
    scan_en = 1'b1;
    for (int r = 0; r < ROWS_N; r++) begin
      x_mat[r] = 8'hFF;
      img_m[r] = 8'h00;
    end

    tbl[0] = '{0, 8'hFF, 0, 10'h000, 10'h000, 10'h000};
    tbl[1] = '{8, 8'hFB, 1, 10'h242, 10'h000, 10'h000};
    tbl[2] = '{8, 8'hFB, 0, 10'h000, 10'h000, 10'h000};
    tbl[3] = '{8, 8'hFF, 1, 10'h042, 10'h000, 10'h000};
    tbl[4] = '{2, 8'h5E, 3, 10'h210, 10'h215, 10'h217};
    tbl[5] = '{2, 8'hFF, 3, 10'h010, 10'h015, 10'h017};
    tbl[6] = '{3, 8'hFD, 1, 10'h219, 10'h000, 10'h000};
    tbl[7] = '{3, 8'hFE, 2, 10'h218, 10'h019, 10'h000};
    tbl[8] = '{3, 8'hFF, 1, 10'h018, 10'h000, 10'h000};

    repeat (3) wait_neg();
    check("rst_Y", int'(Y), 0);
    check("rst_ev", int'(ev), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(scan_done), 0);
    begin_scan();
    reset = 1'b0;

    // Directed vectors: each entry changes one row and runs one full scan.
    for (int t = 0; t < 9; t++) begin
      begin_scan();
      x_mat[tbl[t].row] = tbl[t].x;
      model_scan();
      exp_q.delete();
      if (tbl[t].n > 0) exp_q.push_back(tbl[t].e0);
      if (tbl[t].n > 1) exp_q.push_back(tbl[t].e1);
      if (tbl[t].n > 2) exp_q.push_back(tbl[t].e2);
      run_scan($sformatf("vec%0d", t), 1'b1);
      if (t == 1)
        check("esc_latency", ev_cyc[eb] - y_cyc[yb+8], FIRST_LAT);
    end

    // Reset during the second of three emits, then a full re-report.
    begin_scan();
    x_mat[2] = 8'h5E;
    n = 0;
    while (ev_log.size() - eb < 2 && n < BUDGET) begin
      wait_neg();
      n++;
    end
    check("rstemit_two_ev", ev_log.size() - eb, 2);
    check("rstemit_busy", int'(busy), 1);
    reset = 1'b1;
    wait_neg();
    check("rstemit_ev", int'(ev), 0);
    check("rstemit_Y", int'(Y), 0);
    check("rstemit_busy0", int'(busy), 0);
    check("rstemit_done", int'(scan_done), 0);
    reset = 1'b0;
    for (int r = 0; r < ROWS_N; r++) img_m[r] = 8'h00;
    begin_scan();
    model_scan();
    run_scan("rst_rescan", 1'b1);

    // scan_en dropped while row 4 is in progress: rows 5..9 must not be driven.
    begin_scan();
    x_mat[6] = 8'h7F;
    n = 0;
    while (!(busy && Y == 4'd4) && n < BUDGET) begin
      wait_neg();
      n++;
    end
    check("en_row4", int'(Y), 4);
    scan_en = 1'b0;
    repeat (2500) wait_neg();
    check("en_nodone", done_cnt - d0, 0);
    ym = 0;
    for (int i = yb; i < y_log.size(); i++)
      if (int'(y_log[i]) > ym) ym = int'(y_log[i]);
    check("en_ymax", ym, 4);
    check("en_busy", int'(busy), 0);
    check("en_noev", ev_log.size() - eb, 0);
    begin_scan();
    scan_en = 1'b1;
    model_scan();
    run_scan("reen", 1'b0);

    // Random matrix changes between scans.
    for (int k = 0; k < 10; k++) begin
      begin_scan();
      for (int r = 0; r < ROWS_N; r++) begin
        if ($urandom_range(2) == 0) begin
          v  = 8'hFF;
          np = int'($urandom_range(3));
          for (int j = 0; j < np; j++) v[$urandom_range(7)] = 1'b0;
          x_mat[r] = v;
        end
      end
      model_scan();
      run_scan($sformatf("rnd%0d", k), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
